// File: rtl/captura_pkg.sv
// Shared definitions for the camera capture block: output format codes,
// RGB565 field positions and the two pixel down-conversion functions.
package captura_pkg;

    // Output formats selectable with the MODE parameter
    localparam int MODE_RGB332 = 0;
    localparam int MODE_RGB444 = 1;

    // MSB position of each colour field inside an assembled RGB565 word
    localparam int R_MSB = 15;
    localparam int G_MSB = 10;
    localparam int B_MSB = 4;

    // Width of the sensor column / line counters (covers sensors up to 65535 wide)
    localparam int CNT_W = 16;

    // Capture is idle after reset until the sensor shows the start of a frame
    typedef enum logic [0:0] {
        ST_WAIT_VSYNC = 1'b0,
        ST_CAPTURE    = 1'b1
    } cap_state_e;

    // Stored pixel width for a given format
    function automatic int pix_width(input int mode);
        return (mode == MODE_RGB444) ? 12 : 8;
    endfunction

    // Keep the top 3/3/2 bits of R/G/B
    function automatic logic [7:0] to_rgb332(input logic [15:0] p);
        return {p[R_MSB -: 3], p[G_MSB -: 3], p[B_MSB -: 2]};
    endfunction

    // Keep the top 4/4/4 bits of R/G/B
    function automatic logic [11:0] to_rgb444(input logic [15:0] p);
        return {p[R_MSB -: 4], p[G_MSB -: 4], p[B_MSB -: 4]};
    endfunction

endpackage

// File: rtl/captura_pix_pack.sv
// Pairs the two camera bytes of an RGB565 pixel and converts the completed
// pixel to the stored format. The completion strobe and converted data are
// combinational so the top level can register them together with the address.
module captura_pix_pack
    import captura_pkg::*;
#(
    parameter int MODE = MODE_RGB332,
    parameter int DW   = pix_width(MODE)
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          byte_en,   // active byte on this edge
    input  logic          line_clr,  // HREF low or frame blanking: restart pairing
    input  logic [7:0]    d,
    output logic          pix_done,  // second byte of a pixel is on d now
    output logic [DW-1:0] pix_data
);

    logic       phase_q, phase_d;
    logic [7:0] hi_q, hi_d;
    logic [15:0] rgb565;

    // Byte phase toggles per active byte; a dropped line abandons any half pixel
    always_comb begin
        phase_d = phase_q;
        hi_d    = hi_q;
        if (line_clr) begin
            phase_d = 1'b0;
        end else if (byte_en) begin
            phase_d = ~phase_q;
            if (!phase_q) begin
                hi_d = d;
            end
        end
    end

    // Phase and first-byte holding register
    always_ff @(posedge clk) begin
        if (srst) begin
            phase_q <= 1'b0;
            hi_q    <= 8'd0;
        end else begin
            phase_q <= phase_d;
            hi_q    <= hi_d;
        end
    end

    // Pixel completion and format conversion
    always_comb begin
        rgb565   = {hi_q, d};
        pix_done = byte_en && phase_q;
        if (MODE == MODE_RGB444) begin
            pix_data = DW'(to_rgb444(rgb565));
        end else begin
            pix_data = DW'(to_rgb332(rgb565));
        end
    end

endmodule

// File: rtl/captura_datos_param.sv
// Camera-to-frame-buffer capture: decimates the sensor image, converts each
// kept pixel and issues one RAM write per stored pixel with a running address.
module captura_datos_param
    import captura_pkg::*;
#(
    parameter int  AW    = 15,
    parameter int  MODE  = MODE_RGB332,
    parameter int  H_PIX = 160,
    parameter int  V_PIX = 120,
    parameter int  DECIM = 2,
    localparam int DW    = pix_width(MODE)
) (
    input  logic          PCLK,
    input  logic          RST,
    input  logic          VSYNC,
    input  logic          HREF,
    input  logic [7:0]    D,
    output logic [DW-1:0] DP_RAM_data_in,
    output logic [AW-1:0] DP_RAM_addr_in,
    output logic          DP_RAM_regW,
    output logic          FRAME_DONE,
    output logic          OVF
);

    localparam logic [CNT_W-1:0] DMASK    = CNT_W'((1 << DECIM) - 1);
    localparam logic [CNT_W-1:0] H_LIM    = CNT_W'(H_PIX);
    localparam logic [CNT_W-1:0] V_LIM    = CNT_W'(V_PIX);
    localparam logic [AW-1:0]    ADDR_MAX = '1;

    cap_state_e state_q, state_d;
    logic       cap_en;

    logic             vsync_q, href_q;
    logic [CNT_W-1:0] x_q, x_d;
    logic [CNT_W-1:0] y_q, y_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic             full_q, full_d;
    logic             ovf_q, ovf_d;
    logic             written_q, written_d;
    logic             regw_q, regw_d;
    logic [DW-1:0]    data_q, data_d;
    logic [AW-1:0]    aout_q, aout_d;
    logic             fd_q, fd_d;

    logic          vsync_rise, vsync_fall;
    logic          byte_en, line_clr;
    logic          pix_done;
    logic [DW-1:0] pix_data;
    logic          qualify, issue, drop;

    assign vsync_rise = VSYNC && !vsync_q;
    assign vsync_fall = !VSYNC && vsync_q;
    assign byte_en    = cap_en && HREF && !VSYNC;
    assign line_clr   = !HREF || VSYNC;

    captura_pix_pack #(
        .MODE (MODE),
        .DW   (DW)
    ) u_pix_pack (
        .clk      (PCLK),
        .srst     (RST),
        .byte_en  (byte_en),
        .line_clr (line_clr),
        .d        (D),
        .pix_done (pix_done),
        .pix_data (pix_data)
    );

    // Capture state register
    always_ff @(posedge PCLK) begin
        if (RST) begin
            state_q <= ST_WAIT_VSYNC;
        end else begin
            state_q <= state_d;
        end
    end

    // Arm only at a clean frame start so a partial frame after reset is ignored
    always_comb begin
        state_d = state_q;
        if (state_q == ST_WAIT_VSYNC && vsync_fall) begin
            state_d = ST_CAPTURE;
        end
    end

    // Capture enable decoded from the state
    always_comb begin
        cap_en = (state_q == ST_CAPTURE);
    end

    // Counters, write decision, address and flag next-state
    always_comb begin
        x_d = x_q;
        if (line_clr) begin
            x_d = '0;
        end else if (pix_done) begin
            x_d = x_q + 1'b1;
        end

        y_d = y_q;
        if (VSYNC) begin
            y_d = '0;
        end else if (href_q && !HREF) begin
            y_d = y_q + 1'b1;
        end

        qualify = pix_done
               && ((x_q & DMASK) == '0) && ((y_q & DMASK) == '0)
               && ((x_q >> DECIM) < H_LIM) && ((y_q >> DECIM) < V_LIM);
        // full_q means the last address has already been written
        issue = qualify && !full_q;
        drop  = qualify && full_q;

        addr_d = addr_q;
        full_d = full_q;
        ovf_d  = ovf_q;
        aout_d = aout_q;
        if (VSYNC) begin
            addr_d = '0;
            full_d = 1'b0;
            ovf_d  = 1'b0;
            aout_d = '0;
        end else begin
            if (issue) begin
                aout_d = addr_q;
                if (addr_q == ADDR_MAX) begin
                    full_d = 1'b1;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            if (drop) begin
                ovf_d = 1'b1;
            end
        end

        written_d = written_q;
        if (vsync_rise) begin
            written_d = 1'b0;
        end else if (issue) begin
            written_d = 1'b1;
        end

        fd_d   = vsync_rise && written_q;
        regw_d = issue;
        data_d = issue ? pix_data : data_q;
    end

    // Datapath and flag registers; RAM outputs are registered together
    always_ff @(posedge PCLK) begin
        if (RST) begin
            vsync_q   <= 1'b0;
            href_q    <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            addr_q    <= '0;
            full_q    <= 1'b0;
            ovf_q     <= 1'b0;
            written_q <= 1'b0;
            regw_q    <= 1'b0;
            data_q    <= '0;
            aout_q    <= '0;
            fd_q      <= 1'b0;
        end else begin
            vsync_q   <= VSYNC;
            href_q    <= HREF;
            x_q       <= x_d;
            y_q       <= y_d;
            addr_q    <= addr_d;
            full_q    <= full_d;
            ovf_q     <= ovf_d;
            written_q <= written_d;
            regw_q    <= regw_d;
            data_q    <= data_d;
            aout_q    <= aout_d;
            fd_q      <= fd_d;
        end
    end

    assign DP_RAM_data_in = data_q;
    assign DP_RAM_addr_in = aout_q;
    assign DP_RAM_regW    = regw_q;
    assign FRAME_DONE     = fd_q;
    assign OVF            = ovf_q;

endmodule
